axis_width_adapter: RTL

Parametrised AXI4-Stream data-width converter between two `my_axis_if` ports, one clock domain. Handles upsizing, downsizing or a same-width register slice, selected by the ratio of `S_DATA_W` to `M_DATA_W`. It preserves `tkeep` and `tlast` and drops the unused trailing lanes at packet end. It sits between the UART byte streams and the 128-bit AES datapath, packing bytes into blocks and unpacking blocks into bytes.

---
 rtl/axis_width_adapter_if.sv | 19 +
 rtl/axis_width_adapter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axis_width_adapter_if.sv
// my_axis_if: AXI4-Stream bundle shared by both sides of the width adapter.
//   tdata  : DATA_W-bit payload
//   tkeep  : DATA_W/8 byte qualifiers
//   tlast  : packet boundary marker
//   tvalid : source has a beat
//   tready : sink takes the beat
// The master modport drives payload and tvalid; the slave modport drives tready.
interface my_axis_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_width_adapter.sv
// axis_width_adapter: single-clock AXI4-Stream width converter.
// Packs narrow beats into wide words (upsize), unpacks wide words into narrow
// beats (downsize), or acts as a one-register slice when widths match.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset; clears outputs and partial state
//   s_axis : input stream, S_DATA_W bits (slave modport)
//   m_axis : output stream, M_DATA_W bits (master modport)
// All m_axis fields come from registers; s_axis.tready may follow
// m_axis.tready combinationally.
module axis_width_adapter #(
   parameter int S_DATA_W = 8,
   parameter int M_DATA_W = 128
) (
   input  logic      clk,
   input  logic      rst,
   my_axis_if.slave  s_axis,
   my_axis_if.master m_axis
);
   localparam int LANE_W  = (S_DATA_W < M_DATA_W) ? S_DATA_W : M_DATA_W;
   localparam int WIDE_W  = (S_DATA_W < M_DATA_W) ? M_DATA_W : S_DATA_W;
   localparam int N       = WIDE_W / LANE_W;
   localparam int KEEP_LW = LANE_W / 8;
   localparam int LW      = (N > 1) ? $clog2(N) : 1;

   logic [M_DATA_W-1:0]   r_tdata;
   logic [M_DATA_W/8-1:0] r_tkeep;
   logic                  r_tlast;
   logic                  r_tvalid;
   logic                  w_s_ready;
   logic                  w_in_fire;
   logic                  w_out_fire;

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tkeep  = r_tkeep;
   assign m_axis.tlast  = r_tlast;
   assign m_axis.tvalid = r_tvalid;
   assign s_axis.tready = w_s_ready;

   assign w_in_fire  = s_axis.tvalid & w_s_ready;
   assign w_out_fire = r_tvalid & m_axis.tready;

   if ((S_DATA_W % 8) != 0 || (M_DATA_W % 8) != 0 || (WIDE_W % LANE_W) != 0) begin : g_illegal
      $error("axis_width_adapter: widths must be byte multiples and integer ratios");
   end else if (M_DATA_W >= S_DATA_W) begin : g_up
      // Upsize, and the N=1 slice as its degenerate case (every beat completes).
      logic [LW-1:0]         r_lane;
      logic [M_DATA_W-1:0]   w_word_data;
      logic [M_DATA_W/8-1:0] w_word_keep;
      logic                  w_word_done;

      // A stalled word blocks input, so accepting while r_tvalid implies it
      // leaves this cycle and lane 0 always starts a fresh, cleared word.
      assign w_s_ready = !rst && (!r_tvalid || m_axis.tready);

      always_comb begin
         w_word_data = (r_lane == '0) ? '0 : r_tdata;
         w_word_keep = (r_lane == '0) ? '0 : r_tkeep;
         w_word_data[r_lane*LANE_W +: LANE_W]   = s_axis.tdata;
         w_word_keep[r_lane*KEEP_LW +: KEEP_LW] = s_axis.tkeep;
         w_word_done = s_axis.tlast || (r_lane == LW'(N - 1));
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_lane   <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
         end else begin
            if (w_out_fire) r_tvalid <= 1'b0;
            if (w_in_fire) begin
               r_tdata <= w_word_data;
               r_tkeep <= w_word_keep;
               if (w_word_done) begin
                  r_tvalid <= 1'b1;
                  r_tlast  <= s_axis.tlast;
                  r_lane   <= '0;
               end else begin
                  r_tlast  <= 1'b0;
                  r_lane   <= r_lane + 1'b1;
               end
            end
         end
      end
   end else begin : g_down
      typedef enum logic {ST_IDLE, ST_EMIT} state_t;

      state_t                r_state;
      state_t                w_state_nxt;
      logic [LW-1:0]         r_lane;
      logic [LW-1:0]         w_lane_nxt;
      logic [LW-1:0]         r_final;
      logic [LW-1:0]         w_in_final;
      logic [S_DATA_W-1:0]   r_hold_data;
      logic [S_DATA_W/8-1:0] r_hold_keep;
      logic                  r_hold_last;
      logic                  w_last_lane;

      // Last lane to emit: all lanes mid-packet; at packet end the highest
      // lane carrying any kept byte, falling back to lane 0.
      function automatic logic [LW-1:0] final_lane(input logic [S_DATA_W/8-1:0] keep,
                                                  input logic last);
         final_lane = LW'(N - 1);
         if (last) begin
            final_lane = '0;
            for (int i = 1; i < N; i++)
               if (|keep[i*KEEP_LW +: KEEP_LW]) final_lane = LW'(i);
         end
      endfunction

      assign w_in_final  = final_lane(s_axis.tkeep, s_axis.tlast);
      assign w_last_lane = (r_state == ST_EMIT) && w_out_fire && (r_lane == r_final);
      // Refill on the final lane's transfer keeps words back to back.
      assign w_s_ready   = !rst && ((r_state == ST_IDLE) || w_last_lane);

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= ST_IDLE;
            r_lane  <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_lane_nxt  = r_lane;
         case (r_state)
            ST_IDLE: begin
               if (w_in_fire) begin
                  w_state_nxt = ST_EMIT;
                  w_lane_nxt  = '0;
               end
            end
            ST_EMIT: begin
               if (w_out_fire) begin
                  if (r_lane == r_final) begin
                     w_lane_nxt  = '0;
                     w_state_nxt = w_in_fire ? ST_EMIT : ST_IDLE;
                  end else begin
                     w_lane_nxt  = r_lane + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_lane_nxt  = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_final  <= '0;
         end else if (w_in_fire) begin
            // Lane 0 goes straight to the output register on accept.
            r_hold_data <= s_axis.tdata;
            r_hold_keep <= s_axis.tkeep;
            r_hold_last <= s_axis.tlast;
            r_final     <= w_in_final;
            r_tvalid    <= 1'b1;
            r_tdata     <= s_axis.tdata[M_DATA_W-1:0];
            r_tkeep     <= s_axis.tkeep[M_DATA_W/8-1:0];
            r_tlast     <= s_axis.tlast && (w_in_final == '0);
         end else if (w_out_fire) begin
            if (r_lane == r_final) begin
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
            end else begin
               r_tdata  <= r_hold_data[w_lane_nxt*M_DATA_W +: M_DATA_W];
               r_tkeep  <= r_hold_keep[w_lane_nxt*KEEP_LW +: KEEP_LW];
               r_tlast  <= r_hold_last && (w_lane_nxt == r_final);
            end
         end
      end
   end
endmodule
